// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests and grants.
// An optional hold limit hands the bus on when one owner keeps it too long.
module bus_arbiter #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   output logic       preempt
);

   typedef enum logic [1:0] {
      OWN0 = 2'd0,
      OWN1 = 2'd1,
      OWN2 = 2'd2,
      OWN3 = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] hold_reg, hold_next;
   logic [3:0]       grnt_reg, grnt_next;
   logic             preempt_reg, preempt_next;

   logic [3:0] req;
   logic [1:0] owner_idx;
   logic [2:0] rot;
   logic       own_req;
   logic       other_req;
   logic       at_limit;
   logic [1:0] step;

   assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign owner_idx = state_reg;
   assign own_req   = req[owner_idx];

   // rot[j] is the request of the master j+1 places after the owner.
   for (genvar gi = 0; gi < 3; gi++) begin : g_rot
      assign rot[gi] = req[owner_idx + 2'(gi + 1)];
   end

   assign other_req = |rot;

   always_comb begin
      step = 2'd3;
      if (rot[0]) begin
         step = 2'd1;
      end else if (rot[1]) begin
         step = 2'd2;
      end
   end

   if (HOLD_MAX == 0) begin : g_no_limit
      assign at_limit = 1'b0;
   end else begin : g_limit
      assign at_limit = (hold_reg == CNT_W'(HOLD_MAX - 1));
   end

   always_comb begin
      state_next   = state_reg;
      preempt_next = 1'b0;
      hold_next    = hold_reg;

      if (!own_req) begin
         if (other_req) begin
            state_next = state_t'(owner_idx + step);
         end
      end else if (other_req && at_limit) begin
         state_next   = state_t'(owner_idx + step);
         preempt_next = 1'b1;
      end

      // Saturate so an unlimited owner never wraps the counter.
      if (state_next != state_reg) begin
         hold_next = '0;
      end else if (!other_req) begin
         hold_next = '0;
      end else if (own_req && (hold_reg != {CNT_W{1'b1}})) begin
         hold_next = hold_reg + 1'b1;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_grant
      assign grnt_next[gi] = (state_next != state_t'(gi));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= OWN0;
         hold_reg    <= '0;
         grnt_reg    <= 4'b1110;
         preempt_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         hold_reg    <= hold_next;
         grnt_reg    <= grnt_next;
         preempt_reg <= preempt_next;
      end
   end

   assign m0_grnt_ = grnt_reg[0];
   assign m1_grnt_ = grnt_reg[1];
   assign m2_grnt_ = grnt_reg[2];
   assign m3_grnt_ = grnt_reg[3];
   assign owner    = state_reg;
   assign preempt  = preempt_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (hold limit 16, 4, none) share one
// request stream; hand-derived vector table, then random traffic vs a model.
module tb_bus_arbiter;

   localparam int NI = 3;
   localparam int HOLDS [NI] = '{16, 4, 0};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_n = 4'hF;
   logic [3:0] grnt_n [NI];
   logic [1:0] own [NI];
   logic       pre [NI];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      bus_arbiter #(.HOLD_MAX(HOLDS[gi]), .CNT_W(5)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .m0_req_  (req_n[0]),
         .m1_req_  (req_n[1]),
         .m2_req_  (req_n[2]),
         .m3_req_  (req_n[3]),
         .m0_grnt_ (grnt_n[gi][0]),
         .m1_grnt_ (grnt_n[gi][1]),
         .m2_grnt_ (grnt_n[gi][2]),
         .m3_grnt_ (grnt_n[gi][3]),
         .owner    (own[gi]),
         .preempt  (pre[gi])
      );
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model: owner index and consecutive-hold count per instance.
   int m_owner [NI];
   int m_cnt [NI];
   bit m_pre [NI];

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_owner[i] = 0;
         m_cnt[i]   = 0;
         m_pre[i]   = 1'b0;
      end
   endtask

   function automatic int first_after(input int k, input logic [3:0] r);
      for (int d = 1; d <= 3; d++) begin
         if (r[(k + d) % 4]) return (k + d) % 4;
      end
      return k;
   endfunction

   task automatic model_step(input logic [3:0] r);
      for (int i = 0; i < NI; i++) begin
         int  k;
         int  nk;
         bit  others;
         k      = m_owner[i];
         others = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (j != k && r[j]) others = 1'b1;
         end
         nk       = k;
         m_pre[i] = 1'b0;
         if (!r[k]) begin
            nk = first_after(k, r);
         end else if (HOLDS[i] != 0 && others && m_cnt[i] == HOLDS[i] - 1) begin
            nk       = first_after(k, r);
            m_pre[i] = 1'b1;
         end
         if (nk != k || !others) m_cnt[i] = 0;
         else m_cnt[i] = m_cnt[i] + 1;
         m_owner[i] = nk;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NI; i++) begin
         logic [3:0] eg;
         eg = ~(4'b0001 << m_owner[i]);
         vectors++;
         if (grnt_n[i] !== eg || own[i] !== 2'(m_owner[i]) || pre[i] !== m_pre[i]) begin
            miscompares++;
            $display("FAIL %s inst%0d: got grnt_=%b owner=%0d preempt=%b, want grnt_=%b owner=%0d preempt=%b",
                     tag, i, grnt_n[i], own[i], pre[i], eg, m_owner[i], m_pre[i]);
         end
      end
   endtask

   task automatic cycle(input logic [3:0] r, input string tag);
      req_n = ~r;
      @(posedge clk);
      model_step(r);
      #1;
      check_all(tag);
   endtask

   typedef struct {
      logic [3:0] req;
      int         n;
      logic [1:0] o16;
      logic [1:0] o4;
      logic [1:0] o0;
      logic       p4;
   } vec_t;

   vec_t tbl [17];

   initial begin
      logic [3:0] r;

      tbl[0]  = '{4'b0000, 20, 2'd0, 2'd0, 2'd0, 1'b0};
      tbl[1]  = '{4'b0100,  1, 2'd2, 2'd2, 2'd2, 1'b0};
      tbl[2]  = '{4'b0100,  3, 2'd2, 2'd2, 2'd2, 1'b0};
      tbl[3]  = '{4'b0000,  2, 2'd2, 2'd2, 2'd2, 1'b0};
      tbl[4]  = '{4'b1111,  3, 2'd2, 2'd2, 2'd2, 1'b0};
      tbl[5]  = '{4'b1011,  1, 2'd3, 2'd3, 2'd3, 1'b0};
      tbl[6]  = '{4'b0111,  1, 2'd0, 2'd0, 2'd0, 1'b0};
      tbl[7]  = '{4'b1110,  1, 2'd1, 2'd1, 2'd1, 1'b0};
      tbl[8]  = '{4'b1101,  1, 2'd2, 2'd2, 2'd2, 1'b0};
      tbl[9]  = '{4'b0100,  2, 2'd2, 2'd2, 2'd2, 1'b0};
      tbl[10] = '{4'b0101,  3, 2'd2, 2'd2, 2'd2, 1'b0};
      tbl[11] = '{4'b0101,  1, 2'd2, 2'd0, 2'd2, 1'b1};
      tbl[12] = '{4'b0101,  1, 2'd2, 2'd0, 2'd2, 1'b0};
      tbl[13] = '{4'b0101, 39, 2'd2, 2'd0, 2'd2, 1'b1};
      tbl[14] = '{4'b0001,  1, 2'd0, 2'd0, 2'd0, 1'b0};
      tbl[15] = '{4'b0000,  3, 2'd0, 2'd0, 2'd0, 1'b0};
      tbl[16] = '{4'b1000,  1, 2'd3, 2'd3, 2'd3, 1'b0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_state");
      reset = 1'b0;

      for (int t = 0; t < 17; t++) begin
         for (int c = 0; c < tbl[t].n; c++) begin
            cycle(tbl[t].req, $sformatf("row%0d_c%0d", t, c));
         end
         vectors++;
         if (own[0] !== tbl[t].o16 || own[1] !== tbl[t].o4 || own[2] !== tbl[t].o0 ||
             pre[1] !== tbl[t].p4 || pre[0] !== 1'b0 || pre[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL table_row%0d: got owners=%0d/%0d/%0d preempts=%b%b%b, want owners=%0d/%0d/%0d preempt4=%b",
                     t, own[0], own[1], own[2], pre[0], pre[1], pre[2],
                     tbl[t].o16, tbl[t].o4, tbl[t].o0, tbl[t].p4);
         end
      end

      // Asynchronous reset while owner 3 holds with every master requesting.
      req_n = 4'b0000;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      vectors++;
      if (own[1] !== 2'd0 || grnt_n[1] !== 4'b1110) begin
         miscompares++;
         $display("FAIL async_reset_direct: got owner=%0d grnt_=%b, want owner=0 grnt_=1110", own[1], grnt_n[1]);
      end
      #2 reset = 1'b0;
      cycle(4'b1111, "post_reset_hold");
      cycle(4'b1110, "post_reset_release");

      // Random traffic: each request toggles with probability 1/4.
      r = 4'b0000;
      for (int n = 0; n < 2000; n++) begin
         for (int j = 0; j < 4; j++) begin
            if ($urandom_range(3) == 0) r[j] = ~r[j];
         end
         cycle(r, $sformatf("rand%0d", n));
         if ($urandom_range(199) == 0) begin
            #1 reset = 1'b1;
            #1;
            model_reset();
            check_all("rand_async_reset");
            @(posedge clk);
            #1;
            check_all("rand_reset_held");
            reset = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
